// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: core-side request/response bundle for the memory access controller
interface mem_access_ctrl_if;
  logic req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic we;
  logic [1:0] size;
  logic uns;
  logic busy;
  logic done;
  logic err;
  logic [31:0] rdata;
  modport master(output req, addr, wdata, we, size, uns, input busy, done, err, rdata);
  modport slave(input req, addr, wdata, we, size, uns, output busy, done, err, rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sized/aligned load-store sequencer over a word-wide data memory
module mem_access_ctrl (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus,
  output logic [31:0]        A,
  output logic [31:0]        WD,
  output logic               WE,
  input  logic [31:0]        RD
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, nxt;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [1:0] size_q;
  logic we_q, uns_q, bad_q, bad;
  logic [4:0] sh;
  logic [31:0] lane, keep, ext, merged;
  assign A = {addr_q[31:2], 2'b00};
  assign bus.rdata = rdata_q;
  always_comb begin
    bad = bus.size == 2'd3 || (bus.size == 2'd1 && bus.addr[0]) || (bus.size == 2'd2 && |bus.addr[1:0]);
    sh = {addr_q[1:0], 3'b000};
    lane = RD >> sh;
    keep = size_q == 2'd0 ? 32'hFF : 32'hFFFF;
    ext = size_q == 2'd0 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
          size_q == 2'd1 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : RD;
    merged = size_q == 2'd2 ? wdata_q : (word_q & ~(keep << sh)) | ((wdata_q & keep) << sh);
  end
  always_comb begin
    nxt = state;
    bus.busy = state != IDLE;
    bus.done = state == RESP;
    bus.err = state == RESP && bad_q;
    WE = state == WRITE;
    WD = state == WRITE ? merged : 32'h0;
    unique case (state)
      IDLE:  if (bus.req) nxt = bad ? RESP : (bus.we && bus.size == 2'd2) ? WRITE : READ;
      READ:  nxt = we_q ? WRITE : RESP;
      WRITE: nxt = RESP;
      RESP:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      word_q <= '0;
      rdata_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.req) begin
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
        size_q <= bus.size;
        we_q <= bus.we;
        uns_q <= bus.uns;
        bad_q <= bad;
      end
      if (state == READ) begin
        word_q <= RD;
        if (!we_q) rdata_q <= ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed accesses checked against a transaction-level model every cycle
module tb_mem_access_ctrl;
  logic clk = 0;
  logic rst = 0;
  logic [31:0] A, WD, RD;
  logic WE;
  mem_access_ctrl_if bus();
  mem_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .A(A), .WD(WD), .WE(WE), .RD(RD));
  always #5 clk = ~clk;
  logic [31:0] mem [0:1023] = '{default: '0};
  assign RD = mem[A[11:2]];
  always @(posedge clk) if (WE) mem[A[11:2]] <= WD;
  int passed = 0, total = 0;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction
  // model: one access in flight, described by its latency and its effects
  logic [31:0] smem [0:1023] = '{default: '0};
  logic m_act = 0, acc = 0, m_bad = 0, m_st = 0, m_ld = 0;
  int m_cnt = 0, m_n = 0, cyc = 0;
  logic [31:0] m_a = 0, m_rdata = 0, m_new = 0, m_ld_val = 0;
  logic c_bad;
  int c_n;
  logic [4:0] c_sh;
  logic [31:0] c_w, c_v, c_new, c_ld;
  always_comb begin
    c_bad = bus.size == 2'd3 || (bus.size == 2'd1 && bus.addr[0]) || (bus.size == 2'd2 && bus.addr[1:0] != 2'b00);
    c_n = c_bad ? 1 : (bus.we && bus.size != 2'd2) ? 3 : 2;
    c_sh = 5'(bus.addr[1:0] * 8);
    c_w = smem[bus.addr[11:2]];
    c_v = c_w >> c_sh;
    c_new = bus.size == 2'd0 ? ((c_w & ~(32'hFF << c_sh)) | ({24'h0, bus.wdata[7:0]} << c_sh)) :
            bus.size == 2'd1 ? ((c_w & ~(32'hFFFF << c_sh)) | ({16'h0, bus.wdata[15:0]} << c_sh)) : bus.wdata;
    c_ld = bus.size == 2'd0 ? (bus.uns ? {24'h0, c_v[7:0]} : {{24{c_v[7]}}, c_v[7:0]}) :
           bus.size == 2'd1 ? (bus.uns ? {16'h0, c_v[15:0]} : {{16{c_v[15]}}, c_v[15:0]}) : c_w;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc <= 0;
    if (m_act && m_st && m_cnt == m_n - 1) smem[m_a[11:2]] <= m_new;
    if (!rst) begin
      m_act <= 0;
      m_cnt <= 0;
      m_a <= 0;
      m_rdata <= 0;
    end else if (m_act) begin
      if (m_cnt == m_n) m_act <= 0;
      else begin
        m_cnt <= m_cnt + 1;
        if (m_ld && m_cnt + 1 == m_n) m_rdata <= m_ld_val;
      end
    end else if (bus.req) begin
      acc <= 1;
      m_act <= 1;
      m_cnt <= 1;
      m_a <= {bus.addr[31:2], 2'b00};
      m_bad <= c_bad;
      m_st <= bus.we && !c_bad;
      m_ld <= !bus.we && !c_bad;
      m_n <= c_n;
      m_new <= c_new;
      m_ld_val <= c_ld;
    end
  end
  logic chk_en = 0;
  int done_cnt = 0, acc_cnt = 0, we_cnt = 0;
  logic [31:0] last_wd = 0;
  logic e_done, e_we;
  always_comb begin
    e_done = m_act && m_cnt == m_n;
    e_we = m_act && m_st && m_cnt == m_n - 1;
  end
  always @(negedge clk) if (chk_en) begin
    check("busy", 32'(bus.busy), 32'(m_act));
    check("done", 32'(bus.done), 32'(e_done));
    check("err", 32'(bus.err), 32'(e_done && m_bad));
    check("WE", 32'(WE), 32'(e_we));
    check("WD", WD, e_we ? m_new : 32'h0);
    check("A", A, m_a);
    check("rdata", bus.rdata, m_rdata);
    if (bus.done) done_cnt <= done_cnt + 1;
    if (acc) acc_cnt <= acc_cnt + 1;
    if (WE) begin
      we_cnt <= we_cnt + 1;
      last_wd <= WD;
    end
  end
  task automatic wait_acc(input string nm);
    logic ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = acc;
    end
    check({nm, " accept"}, 32'(ok), 32'd1);
  endtask
  task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [31:0] wd, input logic u);
    bus.req = 1;
    bus.we = w;
    bus.size = sz;
    bus.addr = ad;
    bus.wdata = wd;
    bus.uns = u;
    wait_acc(nm);
    bus.req = 0;
  endtask
  task automatic xfer(input string nm, input logic w, input logic [1:0] sz, input logic [31:0] ad,
                      input logic [31:0] wd, input logic u, input int lat, input logic e);
    int n;
    n = 0;
    issue(nm, w, sz, ad, wd, u);
    for (int i = 1; i <= 8 && n == 0; i++) begin
      @(negedge clk);
      if (bus.done) n = i;
    end
    check({nm, " latency"}, 32'(n), 32'(lat));
    check({nm, " err"}, 32'(bus.err), 32'(e));
  endtask
  task automatic no_done(input string nm);
    int n;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check({nm, " done pulses"}, 32'(n), 32'd0);
  endtask
  int we0, d0, a0;
  int t [4];
  initial begin
    bus.req = 0;
    bus.we = 0;
    bus.size = 0;
    bus.addr = 0;
    bus.wdata = 0;
    bus.uns = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset A", A, 32'h0);
    check("reset WE", 32'(WE), 32'd0);
    rst = 1;
    xfer("preload word", 1, 2'd2, 32'h100, 32'h8899AABB, 0, 2, 0);
    check("preload WD", last_wd, 32'h8899AABB);
    xfer("lb 0x102", 0, 2'd0, 32'h102, 0, 0, 2, 0);
    check("lb 0x102 rdata", bus.rdata, 32'hFFFFFF99);
    xfer("lbu 0x102", 0, 2'd0, 32'h102, 0, 1, 2, 0);
    check("lbu 0x102 rdata", bus.rdata, 32'h00000099);
    we0 = we_cnt;
    xfer("sb 0x101", 1, 2'd0, 32'h101, 32'h0000005A, 0, 3, 0);
    check("sb WD", last_wd, 32'h88995ABB);
    check("sb WE pulses", 32'(we_cnt - we0), 32'd1);
    check("sb keeps rdata", bus.rdata, 32'h00000099);
    xfer("lw 0x100", 0, 2'd2, 32'h100, 0, 0, 2, 0);
    check("lw after sb", bus.rdata, 32'h88995ABB);
    xfer("restore word", 1, 2'd2, 32'h100, 32'h8899AABB, 0, 2, 0);
    xfer("sh 0x102", 1, 2'd1, 32'h102, 32'h1234CAFE, 0, 3, 0);
    check("sh WD", last_wd, 32'hCAFEAABB);
    xfer("lh 0x102", 0, 2'd1, 32'h102, 0, 0, 2, 0);
    check("lh rdata", bus.rdata, 32'hFFFFCAFE);
    xfer("lhu 0x100", 0, 2'd1, 32'h100, 0, 1, 2, 0);
    check("lhu rdata", bus.rdata, 32'h0000AABB);
    we0 = we_cnt;
    xfer("lw 0x103", 0, 2'd2, 32'h103, 0, 0, 1, 1);
    check("misaligned keeps rdata", bus.rdata, 32'h0000AABB);
    xfer("size 11", 0, 2'd3, 32'h100, 0, 0, 1, 1);
    xfer("sh 0x101", 1, 2'd1, 32'h101, 32'hFFFF, 0, 1, 1);
    xfer("sw 0x102", 1, 2'd2, 32'h102, 32'hFFFF, 0, 1, 1);
    check("errors no WE", 32'(we_cnt - we0), 32'd0);
    check("errors keep rdata", bus.rdata, 32'h0000AABB);
    issue("abort in READ", 1, 2'd0, 32'h101, 32'h77, 0);
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    check("abort READ busy", 32'(bus.busy), 32'd0);
    check("abort READ WE", 32'(WE), 32'd0);
    no_done("abort READ");
    xfer("lw after abort", 0, 2'd2, 32'h100, 0, 0, 2, 0);
    check("memory untouched", bus.rdata, 32'hCAFEAABB);
    issue("abort in WRITE", 1, 2'd0, 32'h101, 32'h77, 0);
    @(posedge clk);
    #1;
    check("in WRITE WE", 32'(WE), 32'd1);
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    check("abort WRITE WE", 32'(WE), 32'd0);
    check("abort WRITE busy", 32'(bus.busy), 32'd0);
    no_done("abort WRITE");
    d0 = done_cnt;
    a0 = acc_cnt;
    bus.req = 1;
    for (int i = 0; i < 4; i++) begin
      bus.we = !i[0];
      bus.size = 2'd2;
      bus.addr = 32'h200;
      bus.wdata = i < 2 ? 32'hDEADBEEF : 32'h13579BDF;
      bus.uns = 0;
      wait_acc("b2b");
      t[i] = cyc;
      if (i == 2) check("b2b first load", bus.rdata, 32'hDEADBEEF);
    end
    bus.req = 0;
    repeat (4) @(negedge clk);
    check("b2b second load", bus.rdata, 32'h13579BDF);
    for (int i = 1; i < 4; i++) check("b2b spacing", 32'(t[i] - t[i-1]), 32'd3);
    check("b2b accepts", 32'(acc_cnt - a0), 32'd4);
    check("b2b dones", 32'(done_cnt - d0), 32'd4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 req  input  1  access request from the core; sampled only in IDLE.
REQ-005 addr  input  32  byte address of the access.
REQ-006 wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 uns  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; 1 = misaligned or illegal access, no memory effect.
REQ-013 rdata  output  32  load result, held from done until the next done.
REQ-014 A  output  32  word address to data memory, always {addr_q[31:2],2'b00}.
REQ-015 WD  output  32  write word to data memory.
REQ-016 WE  output  1  data memory write enable; memory writes on rising clk.
REQ-017 RD  input  32  data memory read word, combinational from A, little-endian (byte at A in [7:0]).

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, RESP.
REQ-019 In IDLE with req=1, the block SHALL latch addr, wdata, we, size, uns into internal registers and leave IDLE on the same edge; req is ignored in all other states.
REQ-020 Legality: size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00 SHALL be an error; the transition is IDLE->RESP with err=1, WE never asserted, rdata unchanged.
REQ-021 Legal load: IDLE->READ->RESP; in READ, the block SHALL capture RD, select the lane by addr_q[1:0] (halfword lanes 0/2), and extend per uns into rdata.
REQ-022 Legal word store: IDLE->WRITE->RESP; WD=wdata_q.
REQ-023 Legal byte/halfword store: IDLE->READ->WRITE->RESP; READ captures RD; WRITE drives WD = captured word with only the addressed lane(s) replaced by wdata_q[7:0] / wdata_q[15:0].
REQ-024 WE SHALL be 1 only in WRITE, for exactly one cycle per store.
REQ-025 RESP SHALL assert done=1 for one cycle, with err valid, then return to IDLE; busy=0 in RESP's following cycle.
REQ-026 Latency from accept edge to done: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-027 A back-to-back req held high SHALL be accepted on the first IDLE cycle after RESP; minimum spacing between accepts is one IDLE cycle.
REQ-028 rdata SHALL be updated only by legal loads; stores and errors leave it unchanged.
REQ-029 WD outside WRITE SHALL be 0.
REQ-030 A store followed by a load to the same word SHALL return the stored data (write completes before the next READ).

Reset
REQ-031 With rst=0 at a rising edge: state=IDLE, busy=0, done=0, err=0, rdata=0, WE=0, WD=0, all latched request registers=0 (A=0).
REQ-032 Reset asserted in any state, including WRITE, SHALL abort the access; WE SHALL be 0 from the cycle after the reset edge and no done pulse is produced for the aborted access.

Verification
REQ-033 Memory word 0x100 = 0x8899AABB; load byte addr 0x102, uns=0 -> done 2 cycles after accept, rdata=0xFFFFFF99, err=0; uns=1 -> rdata=0x00000099.
REQ-034 Store byte 0x5A to addr 0x101 over word 0x8899AABB -> one WE pulse with WD=0x88995ABB; following word load of 0x100 -> rdata=0x88995ABB.
REQ-035 Store halfword wdata=0x1234CAFE to addr 0x102 -> WD=0xCAFEAABB (over 0x8899AABB), done 3 cycles after accept.
REQ-036 Load word addr 0x103, then size=11 at 0x100 -> each gives done with err=1 one cycle after accept, WE stays 0, rdata unchanged.
REQ-037 Reset pulled low during WRITE of a sub-word store -> WE=0 from the next cycle, no done, memory word unmodified if reset edge precedes WRITE edge, busy=0.
REQ-038 req held high continuously with alternating word store/load to 0x200 (data 0xDEADBEEF) -> accepts spaced per REQ-027, load returns 0xDEADBEEF, exactly one done per accepted request.
